// File: rtl/ahbl_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
// State encoding, HTRANS/HRESP codes, slave-index width helper.
package ahbl_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Selects one slave's PRDATA/PREADY/PSLVERR by the latched slave index.
// Ports: idx, prdata/pready/pslverr (all slaves) -> rdata, ready, err.
module apb_rsp_mux #(
  parameter int NUM_SLV = 16,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 4
) (
  input  logic [IDX_W-1:0]          idx,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      err
);

  always_comb begin
    rdata = '0;
    ready = 1'b0;
    err   = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (idx == IDX_W'(k)) begin
        rdata = prdata[k*DATA_W +: DATA_W];
        ready = pready[k];
        err   = pslverr[k];
      end
    end
  end

endmodule

// File: rtl/ahbl_apb_bridge_gen.sv
// Parametrised AHB-Lite slave to APB3 master bridge, registered outputs.
// AHB: HSEL/HADDR/HTRANS/HWRITE/HWDATA in, HREADYOUT/HRESP/HRDATA out.
// APB: PSEL/PADDR/PENABLE/PWRITE/PWDATA out, per-slave PRDATA/PREADY/PSLVERR in.
// Optional PREADY timeout: define APB_TIMEOUT_EN.
module ahbl_apb_bridge_gen
  import ahbl_apb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_SLV      = 16,
  parameter int SLV_ADDR_LSB = 8,
  parameter int PADDR_W      = 8,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETN,
  input  logic                      HSEL,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [DATA_W-1:0]         HWDATA,
  input  logic                      HREADYIN,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [DATA_W-1:0]         HRDATA,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic [PADDR_W-1:0]        PADDR,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDX_W = idx_w(NUM_SLV);
  localparam logic [IDX_W:0] NUM_V = (IDX_W+1)'(NUM_SLV);

  state_e             state;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   hidx;
  logic               accept;
  logic               hit;
  logic [NUM_SLV-1:0] sel_next;
  logic [DATA_W-1:0]  sel_rdata;
  logic               sel_ready;
  logic               sel_err;
  logic               unused_in;

  assign hidx   = HADDR[SLV_ADDR_LSB +: IDX_W];
  assign accept = HSEL & HREADYIN & HTRANS[1] & HREADYOUT;
  assign hit    = {1'b0, hidx} < NUM_V;

  always_comb begin
    sel_next = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      sel_next[k] = (hidx == IDX_W'(k));
    end
  end

  apb_rsp_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_rsp_mux (
    .idx     (idx_q),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR),
    .rdata   (sel_rdata),
    .ready   (sel_ready),
    .err     (sel_err)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt;
  assign unused_in = ^{HSIZE, HTRANS[0], HADDR};
`else
  assign unused_in = ^{HSIZE, HTRANS[0], HADDR, (TIMEOUT_CYC == 0)};
`endif

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state     <= IDLE;
      idx_q     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
`ifdef APB_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      unique case (state)
        // ERR2 already shows HREADYOUT=1, so it may accept like IDLE
        IDLE, ERR2: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          if (accept && hit) begin
            state     <= SETUP;
            HREADYOUT <= 1'b0;
            PSEL      <= sel_next;
            PADDR     <= HADDR[PADDR_W-1:0];
            PWRITE    <= HWRITE;
            idx_q     <= hidx;
          end else if (accept) begin
            state     <= ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          // HWDATA is only valid in the data phase
          PWDATA  <= HWDATA;
`ifdef APB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (sel_ready) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            if (sel_err) begin
              state <= ERR1;
              HRESP <= HRESP_ERROR;
            end else begin
              state     <= IDLE;
              HREADYOUT <= 1'b1;
              if (!PWRITE) HRDATA <= sel_rdata;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (cnt == TMO_LAST) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= ERR1;
            HRESP   <= HRESP_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
